// File: rtl/alu_issue_ctrl.sv
// RV32I decode-and-issue sequencer in front of a fixed-latency execute-stage ALU.
// Optional ALU_ISSUE_PERF_EN adds issued/illegal instruction counters.
module alu_issue_ctrl #(
  parameter int ALU_LAT = 2,
  parameter int XLEN    = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_ctrl,
  output logic            alu_flag,
  output logic [1:0]      alu_sel,
  output logic [1:0]      alu_x,
  output logic [1:0]      alu_ctr,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_bt,
  input  logic [XLEN-1:0] alu_jlr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [4:0]      rsp_rd,
  output logic            rsp_we,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_br_taken,
  output logic            rsp_jalr,
  output logic [XLEN-1:0] rsp_target,
`ifdef ALU_ISSUE_PERF_EN
  output logic [31:0]     perf_issued,
  output logic [31:0]     perf_illegal,
`endif
  output logic            rsp_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nx;
  logic [3:0] cnt;
  logic       accept, capture, is_branch_q;

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i;

  logic            dec_legal, dec_flag, dec_we, dec_branch, dec_jalr;
  logic [XLEN-1:0] dec_a, dec_b;
  logic [2:0]      dec_ctrl;
  logic [1:0]      dec_sel, dec_x, dec_ctr;
  logic [4:0]      dec_rd;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};

  // Ready is forced low while reset is held so nothing is accepted during reset.
  assign instr_ready = reset_n && (state == IDLE);
  assign rsp_valid   = (state == RESP);
  assign accept      = instr_valid && instr_ready;
  assign capture     = (state == EXEC) && (cnt == 4'd1);

  always_comb begin
    dec_legal  = 1'b0;
    dec_a      = '0;
    dec_b      = '0;
    dec_ctrl   = 3'd0;
    dec_flag   = 1'b0;
    dec_sel    = 2'd0;
    dec_x      = 2'd0;
    dec_ctr    = 2'd0;
    dec_we     = 1'b0;
    dec_rd     = 5'd0;
    dec_branch = 1'b0;
    dec_jalr   = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_a = rs1_data;
        dec_b = rs2_data;
        case (funct3)
          3'b000: begin
            dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            dec_flag  = funct7[5];
          end
          3'b001: begin
            dec_legal = (funct7 == 7'b0000000);
            dec_ctrl  = 3'd2;
            dec_b     = {27'b0, rs2_data[4:0]};
          end
          3'b010: begin
            dec_legal = (funct7 == 7'b0000000);
            dec_ctrl  = 3'd3;
          end
          3'b100: begin
            dec_legal = (funct7 == 7'b0000000);
            dec_ctrl  = 3'd1;
            dec_sel   = 2'd2;
          end
          3'b101: begin
            dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            dec_ctrl  = 3'd2;
            dec_x     = funct7[5] ? 2'd2 : 2'd1;
            dec_b     = {27'b0, rs2_data[4:0]};
          end
          3'b110: begin
            dec_legal = (funct7 == 7'b0000000);
            dec_ctrl  = 3'd1;
            dec_sel   = 2'd1;
          end
          3'b111: begin
            dec_legal = (funct7 == 7'b0000000);
            dec_ctrl  = 3'd1;
          end
          default: dec_legal = 1'b0;
        endcase
        dec_we = (rd != 5'd0);
        dec_rd = rd;
      end
      OPC_OP_IMM: begin
        dec_a = rs1_data;
        dec_b = imm_i;
        case (funct3)
          3'b000: dec_legal = 1'b1;
          3'b001: begin
            dec_legal = (funct7 == 7'b0000000);
            dec_ctrl  = 3'd2;
            dec_b     = {27'b0, instr[24:20]};
          end
          3'b010: begin
            dec_legal = 1'b1;
            dec_ctrl  = 3'd3;
          end
          3'b100: begin
            dec_legal = 1'b1;
            dec_ctrl  = 3'd1;
            dec_sel   = 2'd2;
          end
          3'b101: begin
            dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            dec_ctrl  = 3'd2;
            dec_x     = funct7[5] ? 2'd2 : 2'd1;
            dec_b     = {27'b0, instr[24:20]};
          end
          3'b110: begin
            dec_legal = 1'b1;
            dec_ctrl  = 3'd1;
            dec_sel   = 2'd1;
          end
          3'b111: begin
            dec_legal = 1'b1;
            dec_ctrl  = 3'd1;
          end
          default: dec_legal = 1'b0;
        endcase
        dec_we = (rd != 5'd0);
        dec_rd = rd;
      end
      OPC_BRANCH: begin
        dec_a      = rs1_data;
        dec_b      = rs2_data;
        dec_ctrl   = 3'd4;
        dec_branch = 1'b1;
        case (funct3)
          3'b000: begin dec_legal = 1'b1; dec_ctr = 2'd0; end
          3'b001: begin dec_legal = 1'b1; dec_ctr = 2'd1; end
          3'b100: begin dec_legal = 1'b1; dec_ctr = 2'd2; end
          3'b101: begin dec_legal = 1'b1; dec_ctr = 2'd3; end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_JALR: begin
        dec_legal = (funct3 == 3'b000);
        dec_a     = rs1_data;
        dec_b     = imm_i;
        dec_ctrl  = 3'd5;
        dec_jalr  = 1'b1;
        dec_rd    = rd;
      end
      default: dec_legal = 1'b0;
    endcase
    // Illegal instructions leave every ALU and response field at zero.
    if (!dec_legal) begin
      dec_a      = '0;
      dec_b      = '0;
      dec_ctrl   = 3'd0;
      dec_flag   = 1'b0;
      dec_sel    = 2'd0;
      dec_x      = 2'd0;
      dec_ctr    = 2'd0;
      dec_we     = 1'b0;
      dec_rd     = 5'd0;
      dec_branch = 1'b0;
      dec_jalr   = 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = dec_legal ? EXEC : RESP;
      EXEC:    if (capture) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      if (accept)
        cnt <= 4'(ALU_LAT);
      else if (state == EXEC)
        cnt <= cnt - 4'd1;
    end
  end

  // ALU operands and response fields are loaded at accept; ALU results land on the final EXEC edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_ctrl     <= 3'd0;
      alu_flag     <= 1'b0;
      alu_sel      <= 2'd0;
      alu_x        <= 2'd0;
      alu_ctr      <= 2'd0;
      is_branch_q  <= 1'b0;
      rsp_rd       <= 5'd0;
      rsp_we       <= 1'b0;
      rsp_data     <= '0;
      rsp_br_taken <= 1'b0;
      rsp_jalr     <= 1'b0;
      rsp_target   <= '0;
      rsp_illegal  <= 1'b0;
    end else if (accept) begin
      alu_a        <= dec_a;
      alu_b        <= dec_b;
      alu_ctrl     <= dec_ctrl;
      alu_flag     <= dec_flag;
      alu_sel      <= dec_sel;
      alu_x        <= dec_x;
      alu_ctr      <= dec_ctr;
      is_branch_q  <= dec_branch;
      rsp_rd       <= dec_rd;
      rsp_we       <= dec_we;
      rsp_data     <= '0;
      rsp_br_taken <= 1'b0;
      rsp_jalr     <= dec_jalr;
      rsp_target   <= '0;
      rsp_illegal  <= !dec_legal;
    end else if (capture) begin
      rsp_data     <= rsp_we ? alu_result : '0;
      rsp_br_taken <= is_branch_q && alu_bt;
      rsp_target   <= rsp_jalr ? {alu_jlr[XLEN-1:1], 1'b0} : '0;
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_issued  <= 32'd0;
      perf_illegal <= 32'd0;
    end else if (accept) begin
      if (dec_legal)
        perf_issued <= perf_issued + 32'd1;
      else
        perf_illegal <= perf_illegal + 32'd1;
    end
  end
`endif

endmodule
